// File: rtl/output_writeback.sv
// output_writeback: buffers the convolution result stream in a small
// register FIFO and writes each sample to external memory.
// Ports:
//   clk, arst_in          clock, async active-high reset
//   start                 pulse in IDLE: clear counters/flags, begin a map
//   in_data/in_valid      signed result sample, no backpressure
//   in_x/in_y/in_ch       sample coordinates
//   ext_mem_write_*       memory write port (addr, din, en, ready)
//   busy/done/overflow    status; done pulses once per map
//   words_written         completed memory writes in this map
module output_writeback #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int EXT_MEM_WIDTH      = 32,
    parameter int EXT_MEM_HEIGHT     = 1 << 20,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int LOG2_OF_FIFO_DEPTH = 3,
    parameter int BASE_ADDR          = 0,
    localparam int AW    = $clog2(EXT_MEM_HEIGHT),
    localparam int XW    = $clog2(FEATURE_MAP_WIDTH),
    localparam int YW    = $clog2(FEATURE_MAP_HEIGHT),
    localparam int CHW   = $clog2(OUTPUT_NB_CHANNELS),
    localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT
                           * OUTPUT_NB_CHANNELS,
    localparam int CNTW  = $clog2(TOTAL) + 1
) (
    input  logic                     clk,
    input  logic                     arst_in,
    input  logic                     start,
    input  logic [IO_DATA_WIDTH-1:0] in_data,
    input  logic                     in_valid,
    input  logic [XW-1:0]            in_x,
    input  logic [YW-1:0]            in_y,
    input  logic [CHW-1:0]           in_ch,
    output logic [AW-1:0]            ext_mem_write_addr,
    output logic [EXT_MEM_WIDTH-1:0] ext_mem_din,
    output logic                     ext_mem_write_en,
    input  logic                     ext_mem_write_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [CNTW-1:0]          words_written
);

    localparam int D  = 2 ** LOG2_OF_FIFO_DEPTH;
    localparam int PW = LOG2_OF_FIFO_DEPTH;
    localparam int FW = LOG2_OF_FIFO_DEPTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [AW-1:0]            addr_mem [D];
    logic [EXT_MEM_WIDTH-1:0] data_mem [D];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [FW-1:0]            count;
    logic [CNTW-1:0]          acc_cnt;

    logic        empty;
    logic        full;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        drop;
    logic [63:0] addr_full;
    logic [AW-1:0]            push_addr;
    logic [EXT_MEM_WIDTH-1:0] push_data;

    // Address is formed at full 64-bit width, then wrapped to the memory.
    assign addr_full = 64'(BASE_ADDR)
                     + (64'(in_y) * 64'(FEATURE_MAP_WIDTH) + 64'(in_x))
                       * 64'(OUTPUT_NB_CHANNELS)
                     + 64'(in_ch);
    assign push_addr = addr_full[AW-1:0];
    assign push_data = EXT_MEM_WIDTH'($signed(in_data));

    assign busy  = (state == RUN) || (state == DRAIN);
    assign done  = (state == DONE);
    assign empty = (count == '0);
    assign full  = (count == FW'(D));

    assign ext_mem_write_en = busy && !empty;
    assign pop      = ext_mem_write_en && ext_mem_write_ready;
    assign push_req = (state == RUN) && in_valid;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign ext_mem_write_addr = ext_mem_write_en ? addr_mem[rd_ptr] : '0;
    assign ext_mem_din        = ext_mem_write_en ? data_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + FW'(1);
                2'b01:   count <= count - FW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state         <= IDLE;
            acc_cnt       <= '0;
            overflow      <= 1'b0;
            words_written <= '0;
        end else begin
            if (pop)      words_written <= words_written + CNTW'(1);
            if (drop)     overflow      <= 1'b1;
            // Dropped samples still count so the map always completes.
            if (push_req) acc_cnt       <= acc_cnt + CNTW'(1);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        acc_cnt       <= '0;
                        overflow      <= 1'b0;
                        words_written <= '0;
                    end
                end
                RUN: begin
                    if (push_req && acc_cnt == CNTW'(TOTAL - 1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (empty) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_writeback.sv
// Directed bench for output_writeback: W=4, H=2, C=2, BASE_ADDR=100.
// Expected addresses and data are computed from the sample index.
module tb_output_writeback;

    logic        clk = 1'b0;
    logic        arst_in;
    logic        start;
    logic [15:0] in_data;
    logic        in_valid;
    logic [1:0]  in_x;
    logic [0:0]  in_y;
    logic [0:0]  in_ch;
    logic [19:0] ext_mem_write_addr;
    logic [31:0] ext_mem_din;
    logic        ext_mem_write_en;
    logic        ext_mem_write_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [4:0]  words_written;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] waddr_q[$];
    logic [31:0] wdata_q[$];

    output_writeback #(
        .FEATURE_MAP_WIDTH (4),
        .FEATURE_MAP_HEIGHT(2),
        .OUTPUT_NB_CHANNELS(2),
        .LOG2_OF_FIFO_DEPTH(3),
        .BASE_ADDR         (100)
    ) dut (
        .clk                (clk),
        .arst_in            (arst_in),
        .start              (start),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_x               (in_x),
        .in_y               (in_y),
        .in_ch              (in_ch),
        .ext_mem_write_addr (ext_mem_write_addr),
        .ext_mem_din        (ext_mem_din),
        .ext_mem_write_en   (ext_mem_write_en),
        .ext_mem_write_ready(ext_mem_write_ready),
        .busy               (busy),
        .done               (done),
        .overflow           (overflow),
        .words_written      (words_written)
    );

    always #5 clk = ~clk;

    // Completed writes, captured mid-cycle when inputs are stable.
    always @(negedge clk) begin
        if (ext_mem_write_en && ext_mem_write_ready) begin
            waddr_q.push_back(ext_mem_write_addr);
            wdata_q.push_back(ext_mem_din);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_data(input int i);
        int v;
        v = i * 37 - 300;
        return 32'(v);
    endfunction

    task automatic send(input int i);
        in_x     = 2'((i / 2) % 4);
        in_y     = 1'(i / 8);
        in_ch    = 1'(i % 2);
        in_data  = 16'(i * 37 - 300);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        waddr_q.delete();
        wdata_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_wr(input int qi, input int sample);
        logic [19:0] a;
        logic [31:0] d;
        a = (qi < waddr_q.size()) ? waddr_q[qi] : 20'hFFFFF;
        d = (qi < wdata_q.size()) ? wdata_q[qi] : 32'hDEADBEEF;
        check($sformatf("wr_addr[%0d]", qi), 64'(a), 64'(100 + sample));
        check($sformatf("wr_data[%0d]", qi), 64'(d), 64'(exp_data(sample)));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_done_lat"}, 64'(n), 64'd2);
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"}, 64'(ext_mem_write_en), 64'd0);
        check({tag, "_addr"}, 64'(ext_mem_write_addr), 64'd0);
        check({tag, "_din"}, 64'(ext_mem_din), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
        check({tag, "_ww"}, 64'(words_written), 64'd0);
    endtask

    initial begin
        arst_in             = 1'b1;
        start               = 1'b0;
        in_data             = '0;
        in_valid            = 1'b0;
        in_x                = '0;
        in_y                = '0;
        in_ch               = '0;
        ext_mem_write_ready = 1'b1;
        #1;
        check_idle_outputs("rst0");
        tick();
        tick();
        arst_in = 1'b0;
        tick();

        // Single sample, then a reset in the middle of the map.
        do_start();
        check("t2_busy", 64'(busy), 64'd1);
        in_x = 2'd1; in_y = 1'd0; in_ch = 1'd1;
        in_data = 16'hFFFD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t2_en", 64'(ext_mem_write_en), 64'd1);
        check("t2_addr", 64'(ext_mem_write_addr), 64'd103);
        check("t2_din", 64'(ext_mem_din), 64'hFFFF_FFFD);
        check("t2_ww0", 64'(words_written), 64'd0);
        tick();
        check("t2_ww1", 64'(words_written), 64'd1);
        check("t2_en_off", 64'(ext_mem_write_en), 64'd0);
        check("t2_addr_off", 64'(ext_mem_write_addr), 64'd0);
        send(1);
        arst_in = 1'b1;
        #1;
        check_idle_outputs("rst1");
        tick();
        check_idle_outputs("rst1n");
        arst_in = 1'b0;
        tick();

        // Full map in raster order.
        do_start();
        for (int i = 0; i < 16; i++) send(i);
        wait_done("t3");
        check("t3_ww", 64'(words_written), 64'd16);
        check("t3_ovf", 64'(overflow), 64'd0);
        check("t3_nwr", 64'(waddr_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) check_wr(i, i);

        // Backpressure: ninth sample is dropped.
        do_start();
        ext_mem_write_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(i);
        check("t4_ovf_8", 64'(overflow), 64'd0);
        send(8);
        check("t4_ovf_9", 64'(overflow), 64'd1);
        check("t4_hold_en", 64'(ext_mem_write_en), 64'd1);
        check("t4_hold_addr", 64'(ext_mem_write_addr), 64'd100);
        check("t4_hold_din", 64'(ext_mem_din), 64'(exp_data(0)));
        ext_mem_write_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("t4_drained", 64'(waddr_q.size()), 64'd8);
        check("t4_en_empty", 64'(ext_mem_write_en), 64'd0);
        for (int i = 0; i < 8; i++) check_wr(i, i);
        for (int i = 9; i < 16; i++) send(i);
        wait_done("t4");
        check("t4_ww", 64'(words_written), 64'd15);
        check("t4_ovf_end", 64'(overflow), 64'd1);
        for (int i = 9; i < 16; i++) check_wr(i - 1, i);

        // Full FIFO with a simultaneous pop: nothing dropped.
        do_start();
        check("t5_ovf_clr", 64'(overflow), 64'd0);
        ext_mem_write_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(i);
        ext_mem_write_ready = 1'b1;
        send(8);
        check("t5_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 8; i++) tick();
        check("t5_occ", 64'(waddr_q.size()), 64'd9);
        check("t5_en_empty", 64'(ext_mem_write_en), 64'd0);
        for (int i = 9; i < 16; i++) send(i);
        wait_done("t5");
        check("t5_ww", 64'(words_written), 64'd16);
        check("t5_ovf_end", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) check_wr(i, i);

        // Ignored inputs: valid in IDLE, start during RUN.
        waddr_q.delete();
        wdata_q.delete();
        for (int i = 0; i < 3; i++) send(i);
        check("t6_idle_nwr", 64'(waddr_q.size()), 64'd0);
        check("t6_idle_en", 64'(ext_mem_write_en), 64'd0);
        check("t6_idle_ww", 64'(words_written), 64'd16);
        check("t6_idle_busy", 64'(busy), 64'd0);
        do_start();
        for (int i = 0; i < 5; i++) send(i);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_run_ww", 64'(words_written), 64'd5);
        check("t6_run_busy", 64'(busy), 64'd1);
        for (int i = 5; i < 16; i++) send(i);
        wait_done("t6");
        check("t6_ww", 64'(words_written), 64'd16);
        check("t6_nwr", 64'(waddr_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) check_wr(i, i);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
